// File: rtl/data_check.sv
// Frame receiver and self-synchronising PRBS checker for the 10-bit framed link test pattern.
// Locks on a comma head, checks the payload against the received-bit history and gathers error statistics.
module data_check #(
    parameter int          PRBS_LENGTH = 8,
    parameter int          SKIP_WORDS  = 2,
    parameter int          POLY_LENGHT = 9,
    parameter int          POLY_TAP    = 5,
    parameter int          INV_PATTERN = 1,
    parameter logic [9:0]  COMMA       = 10'b1100110011,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       data_in,
    input  logic             clear_cnt,
    output logic             lock,
    output logic             frame_done,
    output logic             frame_err,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] bad_frame_cnt
);

    typedef enum logic [1:0] {HUNT, PAYLOAD, TAIL} state_t;

    localparam int                WCNT_W = $clog2(PRBS_LENGTH + 1);
    localparam logic [WCNT_W-1:0] SKIP_C = WCNT_W'(SKIP_WORDS);
    localparam logic [WCNT_W-1:0] LAST_C = WCNT_W'(PRBS_LENGTH - 1);
    localparam logic              INV    = (INV_PATTERN != 0);

    state_t                 state_q, state_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    // hist_q[0] is the most recently received bit, hist_q[i] is i+1 bits back.
    logic [POLY_LENGHT-1:0] hist_q, hist_d;
    logic                   flag_q, flag_d;
    logic                   lock_q, lock_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
    logic [CNT_W-1:0]       berr_q, berr_d;
    logic [CNT_W-1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0]       bad_q, bad_d;

    logic [POLY_LENGHT-1:0] h;
    logic [9:0]             err_vec;
    logic                   pred;
    logic [3:0]             pop;
    logic [CNT_W:0]         berr_sum;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        hist_d   = hist_q;
        flag_d   = flag_q;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
        berr_d   = berr_q;
        fcnt_d   = fcnt_q;
        bad_d    = bad_q;
        h        = hist_q;
        err_vec  = '0;
        pred     = 1'b0;
        pop      = '0;
        berr_sum = '0;

        case (state_q)
            HUNT: begin
                if (data_in == COMMA) begin
                    state_d = PAYLOAD;
                    wcnt_d  = '0;
                    flag_d  = 1'b0;
                end
            end
            PAYLOAD: begin
                // Bit 9 is earliest; later bits of the word see earlier ones in h.
                for (int i = 9; i >= 0; i--) begin
                    pred       = h[POLY_LENGHT-1] ^ h[POLY_TAP-1] ^ INV;
                    err_vec[i] = data_in[i] ^ pred;
                    h          = {h[POLY_LENGHT-2:0], data_in[i]};
                end
                hist_d = h;
                if (wcnt_q >= SKIP_C) begin
                    for (int i = 0; i < 10; i++) pop = pop + 4'(err_vec[i]);
                end
                if (pop != 4'd0) flag_d = 1'b1;
                berr_sum = {1'b0, berr_q} + (CNT_W+1)'(pop);
                berr_d   = berr_sum[CNT_W] ? '1 : berr_sum[CNT_W-1:0];
                if (wcnt_q == LAST_C) state_d = TAIL;
                else                  wcnt_d  = wcnt_q + WCNT_W'(1);
            end
            TAIL: begin
                done_d  = 1'b1;
                ferr_d  = flag_q | (data_in != COMMA);
                state_d = HUNT;
                if (fcnt_q != '1)          fcnt_d = fcnt_q + CNT_W'(1);
                if (ferr_d && bad_q != '1) bad_d  = bad_q + CNT_W'(1);
            end
            default: state_d = HUNT;
        endcase

        lock_d = (state_d != HUNT);

        if (clear_cnt) begin
            berr_d = '0;
            fcnt_d = '0;
            bad_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            wcnt_q  <= '0;
            hist_q  <= '0;
            flag_q  <= 1'b0;
            lock_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            berr_q  <= '0;
            fcnt_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hist_q  <= hist_d;
            flag_q  <= flag_d;
            lock_q  <= lock_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            berr_q  <= berr_d;
            fcnt_q  <= fcnt_d;
            bad_q   <= bad_d;
        end
    end

    assign lock          = lock_q;
    assign frame_done    = done_q;
    assign frame_err     = ferr_q;
    assign bit_err_cnt   = berr_q;
    assign frame_cnt     = fcnt_q;
    assign bad_frame_cnt = bad_q;

endmodule

// File: tb/tb_data_check.sv
// Randomised bench for data_check: a frame-level model with a received-bit queue predicts every output each cycle.
module tb_data_check;

    localparam int         PL    = 8;
    localparam int         SKIP  = 2;
    localparam int         POLY  = 9;
    localparam int         TAP   = 5;
    localparam bit         INV   = 1'b1;
    localparam logic [9:0] COMMA = 10'b1100110011;
    localparam int         CW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    data_in = '0;
    logic          clear_cnt = 1'b0;
    logic          lock, frame_done, frame_err;
    logic [CW-1:0] bit_err_cnt, frame_cnt, bad_frame_cnt;

    data_check #(
        .PRBS_LENGTH(PL), .SKIP_WORDS(SKIP), .POLY_LENGHT(POLY), .POLY_TAP(TAP),
        .INV_PATTERN(1), .COMMA(COMMA), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .clear_cnt(clear_cnt),
        .lock(lock), .frame_done(frame_done), .frame_err(frame_err),
        .bit_err_cnt(bit_err_cnt), .frame_cnt(frame_cnt), .bad_frame_cnt(bad_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: position in frame (-1 hunting, 0..PL-1 payload, PL tail)
    int          pos;
    bit          flag;
    bit          hq[$];
    logic [31:0] m_berr, m_fcnt, m_bad;
    bit          m_lock, m_done, m_ferr;
    bit          gq[$];

    int          done_seen, lock_cycles;
    bit          last_ferr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        pos = -1; flag = 0;
        hq.delete();
        for (int i = 0; i < 16; i++) hq.push_back(1'b0);
        m_berr = 0; m_fcnt = 0; m_bad = 0;
        m_lock = 0; m_done = 0; m_ferr = 0;
    endtask

    task automatic model_step(input logic [9:0] w, input bit clr);
        m_done = 0; m_ferr = 0;
        if (pos < 0) begin
            if (w == COMMA) begin pos = 0; flag = 0; end
        end else if (pos < PL) begin
            int e = 0;
            for (int b = 9; b >= 0; b--) begin
                bit r, p;
                r = w[b];
                p = hq[hq.size()-POLY] ^ hq[hq.size()-TAP] ^ INV;
                if (pos >= SKIP && r != p) e++;
                hq.push_back(r);
            end
            while (hq.size() > 16) void'(hq.pop_front());
            if (e > 0) flag = 1;
            m_berr += e;
            pos++;
        end else begin
            m_done = 1;
            m_ferr = flag || (w != COMMA);
            m_fcnt++;
            if (m_ferr) m_bad++;
            pos = -1;
        end
        m_lock = (pos >= 0);
        if (clr) begin m_berr = 0; m_fcnt = 0; m_bad = 0; end
    endtask

    task automatic check_outputs();
        chk("lock", lock, m_lock);
        chk("frame_done", frame_done, m_done);
        if (m_done) chk("frame_err", frame_err, m_ferr);
        chk("bit_err_cnt", bit_err_cnt, m_berr);
        chk("frame_cnt", frame_cnt, m_fcnt);
        chk("bad_frame_cnt", bad_frame_cnt, m_bad);
    endtask

    task automatic observe();
        if (lock) lock_cycles++;
        if (frame_done) begin done_seen++; last_ferr = frame_err; end
    endtask

    task automatic send(input logic [9:0] w, input bit clr);
        data_in = w; clear_cnt = clr;
        @(posedge clk);
        model_step(w, clr);
        #1;
        check_outputs();
        observe();
        clear_cnt = 1'b0;
    endtask

    task automatic do_reset(input logic [9:0] w);
        data_in = w; rst = 1'b1; clear_cnt = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    function automatic bit next_bit();
        bit b;
        b = ~(gq[gq.size()-POLY] ^ gq[gq.size()-TAP]);
        gq.push_back(b);
        while (gq.size() > 16) void'(gq.pop_front());
        return b;
    endfunction

    function automatic logic [9:0] gen_word();
        logic [9:0] w;
        for (int b = 9; b >= 0; b--) w[b] = next_bit();
        return w;
    endfunction

    task automatic send_frame(input int flip_w, input int flip_b, input bit bad_tail,
                              input bit clr_tail, input int rst_at);
        logic [9:0] w;
        send(COMMA, 1'b0);
        for (int k = 0; k < PL; k++) begin
            w = gen_word();
            if (k == flip_w) w[flip_b] = ~w[flip_b];
            if (k == rst_at) begin do_reset(w); return; end
            send(w, 1'b0);
        end
        send(bad_tail ? 10'd0 : COMMA, clr_tail);
    endtask

    task automatic clr_stats();
        done_seen = 0; lock_cycles = 0; last_ferr = 0;
    endtask

    initial begin
        for (int i = 0; i < POLY; i++) gq.push_back(1'($urandom));
        model_reset();
        do_reset(10'd0);
        chk("rst_lock", lock, 0);
        chk("rst_fcnt", frame_cnt, 0);

        // Idle zeros never lock
        clr_stats();
        for (int i = 0; i < 20; i++) send(10'd0, 1'b0);
        chk("idle_done", done_seen, 0);
        chk("idle_lock", lock_cycles, 0);

        // Clean frame
        clr_stats();
        send_frame(-1, 0, 0, 0, -1);
        chk("clean_done", done_seen, 1);
        chk("clean_ferr", last_ferr, 0);
        chk("clean_fcnt", frame_cnt, 1);
        chk("clean_berr", bit_err_cnt, 0);
        chk("clean_lock_cyc", lock_cycles, 9);

        // Single flip in checked word 4
        do_reset(10'd0);
        clr_stats();
        send_frame(4, int'($urandom_range(0, 9)), 0, 0, -1);
        chk("flip4_ferr", last_ferr, 1);
        chk("flip4_bad", bad_frame_cnt, 1);
        chk("flip4_berr_rng", (bit_err_cnt >= 1 && bit_err_cnt <= 3), 1);

        // Flip in skipped word 0 goes unnoticed
        do_reset(10'd0);
        clr_stats();
        send_frame(0, int'($urandom_range(0, 9)), 0, 0, -1);
        chk("flip0_ferr", last_ferr, 0);
        chk("flip0_berr", bit_err_cnt, 0);

        // Bad tail, then a back-to-back good frame
        do_reset(10'd0);
        clr_stats();
        send_frame(-1, 0, 1, 0, -1);
        chk("badtail_ferr", last_ferr, 1);
        chk("badtail_berr", bit_err_cnt, 0);
        send_frame(-1, 0, 0, 0, -1);
        chk("b2b_fcnt", frame_cnt, 2);
        chk("b2b_bad", bad_frame_cnt, 1);
        chk("b2b_last_ferr", last_ferr, 0);

        // 100 back-to-back frames, clear on the last frame_done cycle
        do_reset(10'd0);
        clr_stats();
        for (int f = 0; f < 100; f++) send_frame(-1, 0, 0, 0, -1);
        chk("x100_done", done_seen, 100);
        chk("x100_lock_cyc", lock_cycles, 900);
        chk("x100_fcnt", frame_cnt, 100);
        chk("x100_done_now", frame_done, 1);
        send(10'd0, 1'b1);
        chk("clr_fcnt", frame_cnt, 0);
        chk("clr_berr", bit_err_cnt, 0);
        send_frame(-1, 0, 0, 0, -1);
        chk("post_clr_fcnt", frame_cnt, 1);

        // Clear wins over a same-cycle increment
        send_frame(-1, 0, 1, 1, -1);
        chk("clr_prio_done", frame_done, 1);
        chk("clr_prio_fcnt", frame_cnt, 0);
        chk("clr_prio_bad", bad_frame_cnt, 0);

        // Reset mid-frame at payload word 3, then a clean frame
        do_reset(10'd0);
        clr_stats();
        send_frame(-1, 0, 0, 0, 3);
        chk("rstmid_lock", lock, 0);
        send_frame(-1, 0, 0, 0, -1);
        chk("rstmid_done", done_seen, 1);
        chk("rstmid_fcnt", frame_cnt, 1);
        chk("rstmid_ferr", last_ferr, 0);

        // Random traffic: gaps, flips, bad tails, random clears
        for (int f = 0; f < 60; f++) begin
            int gap;
            logic [9:0] g;
            gap = int'($urandom_range(0, 3));
            for (int i = 0; i < gap; i++) begin
                g = 10'($urandom);
                if (g == COMMA) g = g ^ 10'd1;
                send(g, ($urandom_range(0, 15) == 0));
            end
            send_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, PL-1)) : -1,
                       int'($urandom_range(0, 9)),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
